// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default sizing for the serial slice adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;
  localparam int NS_DEF = WIDTH_DEF / SLICE_DEF;
  localparam int CNT_W_DEF = NS_DEF > 1 ? $clog2(NS_DEF) : 1;
endpackage

// File: rtl/add4_slice.sv
// add4_slice: combinational W-bit carry-lookahead adder (a, b, cin -> s, cout), each carry expanded from generate/propagate terms
module add4_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W-1:0] g, p;
  logic [W:0] c;
  logic pp, acc;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c = '0;
    pp = 1'b1;
    acc = 1'b0;
    for (int i = 0; i <= W; i++) begin
      pp = 1'b1;
      acc = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i] = acc | (pp & cin);
    end
  end
  assign s = p ^ c[W-1:0];
  assign cout = c[W];
endmodule

// File: rtl/serial_add16_ctrl.sv
// serial_add16_ctrl: WIDTH-bit add via one shared SLICE-bit slice, LS slice first; ports clk, rst, in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy; SERIAL_ADD_SUB_EN adds input sub (a - b)
module serial_add16_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NS = WIDTH / SLICE;
  localparam int CW = NS > 1 ? $clog2(NS) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic carry, sub_i, last, s_co;
  logic [WIDTH-1:0] opa, opb;
  logic [SLICE-1:0] s_sum;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign last = cnt == CW'(NS - 1);
  add4_slice #(.W(SLICE)) u_slice (
    .a    (opa[cnt*SLICE +: SLICE]),
    .b    (opb[cnt*SLICE +: SLICE]),
    .cin  (carry),
    .s    (s_sum),
    .cout (s_co)
  );
  always_comb begin
    state_n = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    state_n = state == IDLE ? (in_valid ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : state == DONE ? (out_ready ? IDLE : DONE)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      opa <= '0;
      opb <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        opa <= a;
        opb <= sub_i ? ~b : b;
        carry <= sub_i | cin;
        cnt <= '0;
        sum <= '0;
        cout <= 1'b0;
      end else if (state == RUN) begin
        sum[cnt*SLICE +: SLICE] <= s_sum;
        carry <= s_co;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) cout <= s_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add16_ctrl.sv
// tb_serial_add16_ctrl: scoreboard bench for serial_add16_ctrl covering latency, carry chains, backpressure, RUN-time input changes and mid-run reset
module tb_serial_add16_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [15:0] sum;
  typedef struct packed { logic [15:0] s; logic c; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_add16_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic isub, input bit push);
    int n = 0;
    logic [16:0] r;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = ia; b = ib; cin = ic; sub = isub; in_valid = 1'b1;
    r = isub ? {1'b0, ia} + {1'b0, ~ib} + 17'd1 : {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
    if (push) q.push_back('{s: r[15:0], c: r[16]});
    tick();
    in_valid = 1'b0;
  endtask
  task automatic recv(input int lat, input int hold);
    int n = 0;
    exp_t e;
    chk("busy_run", 32'(busy), 32'd1);
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", n, lat);
    e = q.size() > 0 ? q.pop_front() : '0;
    chk("sum", 32'(sum), 32'(e.s));
    chk("cout", 32'(cout), 32'(e.c));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(e.s));
      chk("hold_cout", 32'(cout), 32'(e.c));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    recv(4, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    recv(4, 0);
    send(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    recv(4, 10);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    a = 16'hAAAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    recv(3, 0);
    send(16'h9999, 16'h7777, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b1);
    recv(4, 0);
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1);
      recv(4, i % 3);
    end
`ifdef SERIAL_ADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    recv(4, 0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
    recv(4, 0);
    send(16'h0007, 16'h0005, 1'b0, 1'b0, 1'b1);
    recv(4, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
